// File: rtl/hsem_irq_ctrl.sv
// HSEM interrupt/error controller: per-core free-event pending/enable/SWI with level
// interrupts, plus global sticky error flags, first-error capture and saturating error count.
module hsem_irq_ctrl #(
   parameter int NUM_CORES = 2,
   parameter int NUM_SEMS  = 32,
   parameter int AW        = 6,
   parameter int CNT_W     = 8,
   parameter int CID_W     = 3
) (
   input  logic                 hclk,
   input  logic                 hreset,
   input  logic                 wr_en,
   input  logic                 rd_en,
   input  logic [AW-1:0]        addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   input  logic [NUM_SEMS-1:0]  sem_free,
   input  logic [NUM_SEMS-1:0]  sem_err,
   input  logic [CID_W-1:0]     err_master,
   output logic [NUM_CORES-1:0] intr
);

   localparam logic [AW-1:0]    G_ERR   = AW'(4 * NUM_CORES);
   localparam logic [AW-1:0]    G_FERR  = AW'(4 * NUM_CORES + 1);
   localparam logic [AW-1:0]    G_ECNT  = AW'(4 * NUM_CORES + 2);
   localparam logic [AW-1:0]    G_EIE   = AW'(4 * NUM_CORES + 3);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [NUM_CORES-1:0][NUM_SEMS-1:0] ier_q, ier_d;
   logic [NUM_CORES-1:0][NUM_SEMS-1:0] isr_q, isr_d;
   logic [NUM_CORES-1:0]               swi_q, swi_d;
   logic [NUM_CORES-1:0]               eie_q, eie_d;
   logic [NUM_SEMS-1:0]                err_q, err_d;
   logic                               ferr_valid_q, ferr_valid_d;
   logic [CID_W-1:0]                   ferr_master_q, ferr_master_d;
   logic [4:0]                         ferr_idx_q, ferr_idx_d;
   logic [CNT_W-1:0]                   ecnt_q, ecnt_d;
   logic [31:0]                        rdata_q, rdata_d;

   logic                               ferr_clr_s;
   logic                               ecnt_clr_s;
   logic                               ferr_base_valid_s;
   logic [CNT_W-1:0]                   ecnt_base_s;
   logic [31:0]                        core_word_s;
   logic [31:0]                        glob_word_s;

   function automatic logic [4:0] lowest_idx(input logic [NUM_SEMS-1:0] v);
      logic [4:0] r;
      r = 5'd0;
      for (int i = NUM_SEMS - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = 5'(i);
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] core_word(input logic [NUM_SEMS-1:0] ier,
                                             input logic [NUM_SEMS-1:0] isr,
                                             input logic                swi,
                                             input logic [1:0]          off);
      logic [31:0] w;
      w = 32'd0;
      case (off)
         2'd0:    w[NUM_SEMS-1:0] = ier;
         2'd1:    w[NUM_SEMS-1:0] = isr;
         2'd2:    w[NUM_SEMS-1:0] = isr & ier;
         2'd3:    w[0] = swi;
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   // Per-core register next state; W1C is applied before the event OR so a same-cycle set wins.
   always_comb begin
      ier_d = ier_q;
      isr_d = isr_q;
      swi_d = swi_q;
      for (int c = 0; c < NUM_CORES; c++) begin
         if (wr_en && (addr == AW'(4 * c))) begin
            ier_d[c] = wdata[NUM_SEMS-1:0];
         end else begin
            ier_d[c] = ier_q[c];
         end
         if (wr_en && (addr == AW'(4 * c + 1))) begin
            isr_d[c] = (isr_q[c] & ~wdata[NUM_SEMS-1:0]) | sem_free;
         end else begin
            isr_d[c] = isr_q[c] | sem_free;
         end
         if (wr_en && (addr == AW'(4 * c + 3))) begin
            swi_d[c] = wdata[0];
         end else begin
            swi_d[c] = swi_q[c];
         end
      end
   end

   // Global error state next state; a clear and a new error in one cycle keep the new error.
   always_comb begin
      ferr_clr_s        = wr_en && (addr == G_FERR);
      ecnt_clr_s        = wr_en && (addr == G_ECNT);
      ferr_base_valid_s = ferr_clr_s ? 1'b0 : ferr_valid_q;
      ecnt_base_s       = ecnt_clr_s ? {CNT_W{1'b0}} : ecnt_q;

      if (wr_en && (addr == G_ERR)) begin
         err_d = (err_q & ~wdata[NUM_SEMS-1:0]) | sem_err;
      end else begin
         err_d = err_q | sem_err;
      end

      if (wr_en && (addr == G_EIE)) begin
         eie_d = wdata[NUM_CORES-1:0];
      end else begin
         eie_d = eie_q;
      end

      if (!ferr_base_valid_s && (|sem_err)) begin
         ferr_valid_d  = 1'b1;
         ferr_master_d = err_master;
         ferr_idx_d    = lowest_idx(sem_err);
      end else if (ferr_clr_s) begin
         ferr_valid_d  = 1'b0;
         ferr_master_d = {CID_W{1'b0}};
         ferr_idx_d    = 5'd0;
      end else begin
         ferr_valid_d  = ferr_valid_q;
         ferr_master_d = ferr_master_q;
         ferr_idx_d    = ferr_idx_q;
      end

      if ((|sem_err) && (ecnt_base_s != CNT_MAX)) begin
         ecnt_d = ecnt_base_s + CNT_W'(1);
      end else begin
         ecnt_d = ecnt_base_s;
      end
   end

   // Read mux from pre-write register values; unmapped addresses and idle cycles give zero.
   always_comb begin
      core_word_s = 32'd0;
      for (int c = 0; c < NUM_CORES; c++) begin
         core_word_s = core_word_s |
                       ((addr[AW-1:2] == (AW-2)'(c)) ?
                        core_word(ier_q[c], isr_q[c], swi_q[c], addr[1:0]) : 32'd0);
      end

      glob_word_s = 32'd0;
      case (addr)
         G_ERR:  glob_word_s[NUM_SEMS-1:0] = err_q;
         G_FERR: begin
            glob_word_s[31]          = ferr_valid_q;
            glob_word_s[16+:CID_W]   = ferr_master_q;
            glob_word_s[4:0]         = ferr_idx_q;
         end
         G_ECNT:  glob_word_s[CNT_W-1:0] = ecnt_q;
         G_EIE:   glob_word_s[NUM_CORES-1:0] = eie_q;
         default: glob_word_s = 32'd0;
      endcase

      if (rd_en) begin
         rdata_d = core_word_s | glob_word_s;
      end else begin
         rdata_d = 32'd0;
      end
   end

   // State registers with synchronous reset taking priority over all events and accesses.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         ier_q         <= '{default: '0};
         isr_q         <= '{default: '0};
         swi_q         <= {NUM_CORES{1'b0}};
         eie_q         <= {NUM_CORES{1'b0}};
         err_q         <= {NUM_SEMS{1'b0}};
         ferr_valid_q  <= 1'b0;
         ferr_master_q <= {CID_W{1'b0}};
         ferr_idx_q    <= 5'd0;
         ecnt_q        <= {CNT_W{1'b0}};
         rdata_q       <= 32'd0;
      end else begin
         ier_q         <= ier_d;
         isr_q         <= isr_d;
         swi_q         <= swi_d;
         eie_q         <= eie_d;
         err_q         <= err_d;
         ferr_valid_q  <= ferr_valid_d;
         ferr_master_q <= ferr_master_d;
         ferr_idx_q    <= ferr_idx_d;
         ecnt_q        <= ecnt_d;
         rdata_q       <= rdata_d;
      end
   end

   // Level interrupts derived purely from registered state.
   always_comb begin
      intr = {NUM_CORES{1'b0}};
      for (int c = 0; c < NUM_CORES; c++) begin
         intr[c] = (|(isr_q[c] & ier_q[c])) | swi_q[c] | (eie_q[c] & (|err_q));
      end
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_hsem_irq_ctrl.sv
// Bench for hsem_irq_ctrl: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic checked against a behavioural model of the register map.
module tb_hsem_irq_ctrl;
   localparam int NC = 2;
   localparam int NS = 32;
   localparam int AW = 6;
   localparam int CW = 8;
   localparam int IW = 3;
   localparam int G  = 4 * NC;

   logic          hclk = 1'b0;
   logic          hreset;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic [NS-1:0] sem_free;
   logic [NS-1:0] sem_err;
   logic [IW-1:0] err_master;
   logic [NC-1:0] intr;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 hclk = ~hclk;

   hsem_irq_ctrl #(
      .NUM_CORES(NC), .NUM_SEMS(NS), .AW(AW), .CNT_W(CW), .CID_W(IW)
   ) dut (
      .hclk(hclk), .hreset(hreset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .sem_free(sem_free), .sem_err(sem_err),
      .err_master(err_master), .intr(intr)
   );

   typedef struct {
      logic          rst;
      logic          w;
      logic          r;
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic [31:0]   fr;
      logic [31:0]   er;
      logic [IW-1:0] m;
      logic [31:0]   exp_rd;
      logic [NC-1:0] exp_intr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic w, input logic r,
                               input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [31:0] fr, input logic [31:0] er,
                               input logic [IW-1:0] m, input logic [31:0] exp_rd,
                               input logic [NC-1:0] exp_intr);
      vec_t v;
      v.rst = rst; v.w = w; v.r = r; v.a = a; v.d = d;
      v.fr = fr; v.er = er; v.m = m; v.exp_rd = exp_rd; v.exp_intr = exp_intr;
      return v;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One bus/event cycle: drive on the falling edge, return 1 time unit after the rising edge.
   task automatic step(input logic rst, input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [31:0] fr, input logic [31:0] er,
                       input logic [IW-1:0] m);
      @(negedge hclk);
      hreset = rst; wr_en = w; rd_en = r; addr = a; wdata = d;
      sem_free = fr; sem_err = er; err_master = m;
      @(posedge hclk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 3'd0);
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_ier [NC];
   logic [31:0] m_isr [NC];
   bit          m_swi [NC];
   logic [31:0] m_err;
   bit          m_fv;
   int          m_fm;
   int          m_fi;
   int          m_ecnt;
   logic [31:0] m_eie;
   logic [31:0] m_rd;

   function automatic logic [31:0] model_read(input int a);
      int c;
      if (a < G) begin
         c = a / 4;
         case (a % 4)
            0:       return m_ier[c];
            1:       return m_isr[c];
            2:       return m_isr[c] & m_ier[c];
            default: return m_swi[c] ? 32'd1 : 32'd0;
         endcase
      end
      if (a == G)     return m_err;
      if (a == G + 1) return (m_fv ? 32'h8000_0000 : 32'd0) | (32'(m_fm) << 16) | 32'(m_fi);
      if (a == G + 2) return 32'(m_ecnt);
      if (a == G + 3) return m_eie;
      return 32'd0;
   endfunction

   function automatic logic [NC-1:0] model_intr();
      logic [NC-1:0] r;
      for (int c = 0; c < NC; c++) begin
         r[c] = ((m_isr[c] & m_ier[c]) != 32'd0) || m_swi[c] || (m_eie[c] && (m_err != 32'd0));
      end
      return r;
   endfunction

   task automatic model_step(input bit rst, input bit w, input bit r, input int a,
                             input logic [31:0] d, input logic [31:0] fr,
                             input logic [31:0] er, input int m);
      if (rst) begin
         for (int c = 0; c < NC; c++) begin
            m_ier[c] = 32'd0; m_isr[c] = 32'd0; m_swi[c] = 1'b0;
         end
         m_err = 32'd0; m_fv = 1'b0; m_fm = 0; m_fi = 0; m_ecnt = 0; m_eie = 32'd0; m_rd = 32'd0;
         return;
      end
      m_rd = r ? model_read(a) : 32'd0;
      if (w) begin
         if (a < G) begin
            case (a % 4)
               0:       m_ier[a / 4] = d;
               1:       m_isr[a / 4] = m_isr[a / 4] & ~d;
               3:       m_swi[a / 4] = d[0];
               default: ;
            endcase
         end else if (a == G) begin
            m_err = m_err & ~d;
         end else if (a == G + 1) begin
            m_fv = 1'b0; m_fm = 0; m_fi = 0;
         end else if (a == G + 2) begin
            m_ecnt = 0;
         end else if (a == G + 3) begin
            m_eie = d & ((32'd1 << NC) - 32'd1);
         end
      end
      for (int c = 0; c < NC; c++) m_isr[c] = m_isr[c] | fr;
      m_err = m_err | er;
      if (er != 32'd0) begin
         if (!m_fv) begin
            m_fv = 1'b1;
            m_fm = m;
            for (int i = 0; i < NS; i++) begin
               if (er[i]) begin
                  m_fi = i;
                  break;
               end
            end
         end
         m_ecnt = (m_ecnt < (1 << CW) - 1) ? m_ecnt + 1 : (1 << CW) - 1;
      end
   endtask

   initial begin
      hreset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
      sem_free = '0; sem_err = '0; err_master = '0;

      //         rst   w     r     addr   wdata          free           err            m     exp_rdata      intr
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 6'd0,  32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 6'd4,  32'h4,         32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0,  32'd0,         32'h4,         32'd0,         3'd0, 32'd0,         2'b10));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd6,  32'd0,         32'd0,         32'd0,         3'd0, 32'h4,         2'b10));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 6'd5,  32'h4,         32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd1,  32'd0,         32'd0,         32'd0,         3'd0, 32'h4,         2'b00));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 6'd1,  32'h20,        32'h20,        32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd1,  32'd0,         32'd0,         32'd0,         3'd0, 32'h24,        2'b00));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 6'd1,  32'h20,        32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd1,  32'd0,         32'd0,         32'd0,         3'd0, 32'h4,         2'b00));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 6'd11, 32'h1,         32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0,  32'd0,         32'd0,         32'h300,       3'd1, 32'd0,         2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd8,  32'd0,         32'd0,         32'd0,         3'd0, 32'h300,       2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd9,  32'd0,         32'd0,         32'd0,         3'd0, 32'h8001_0008, 2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0,  32'd0,         32'd0,         32'h1,         3'd0, 32'd0,         2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd9,  32'd0,         32'd0,         32'd0,         3'd0, 32'h8001_0008, 2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd10, 32'd0,         32'd0,         32'd0,         3'd0, 32'd2,         2'b01));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 6'd8,  32'h301,       32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 6'd3,  32'h1,         32'd0,         32'd0,         3'd0, 32'd0,         2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd3,  32'd0,         32'd0,         32'd0,         3'd0, 32'd1,         2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd12, 32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b01));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 6'd9,  32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd9,  32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd63, 32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b01));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0,  32'd0,         32'hFF,        32'h10,        3'd0, 32'd0,         2'b11));
      tbl.push_back(mk(1'b1, 1'b1, 1'b1, 6'd4,  32'hFFFF,      32'h1,         32'h1,         3'd2, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd1,  32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd8,  32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd4,  32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd9,  32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b00));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 6'd3,  32'd0,         32'd0,         32'd0,         3'd0, 32'd0,         2'b00));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].fr, tbl[i].er, tbl[i].m);
         check32($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rd);
         check32($sformatf("vec%0d intr", i), {30'd0, intr}, {30'd0, tbl[i].exp_intr});
      end

      // Counter saturation, then clear colliding with an error.
      step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 3'd0);
      for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 32'h8, 3'd2);
      step(1'b0, 1'b0, 1'b1, 6'd10, 32'd0, 32'd0, 32'd0, 3'd0);
      check32("ecnt saturate", rdata, 32'd255);
      step(1'b0, 1'b0, 1'b1, 6'd9, 32'd0, 32'd0, 32'd0, 3'd0);
      check32("ferr after burst", rdata, 32'h8002_0003);
      step(1'b0, 1'b1, 1'b0, 6'd10, 32'd0, 32'd0, 32'h1, 3'd0);
      step(1'b0, 1'b0, 1'b1, 6'd10, 32'd0, 32'd0, 32'd0, 3'd0);
      check32("ecnt clr+err", rdata, 32'd1);

      // FERR clear with a new error in the same cycle captures the new one.
      step(1'b0, 1'b1, 1'b0, 6'd9, 32'd0, 32'd0, 32'h4000_0000, 3'd5);
      step(1'b0, 1'b0, 1'b1, 6'd9, 32'd0, 32'd0, 32'd0, 3'd0);
      check32("ferr clr+err", rdata, 32'h8005_001E);

      // ERR W1C-all colliding with a new error bit, then routing to core 1 only.
      step(1'b0, 1'b1, 1'b0, 6'd8, 32'hFFFF_FFFF, 32'd0, 32'h80, 3'd0);
      step(1'b0, 1'b0, 1'b1, 6'd8, 32'd0, 32'd0, 32'd0, 3'd0);
      check32("err w1c collide", rdata, 32'h80);
      check32("intr eie off", {30'd0, intr}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 6'd11, 32'hFFFF_FFFE, 32'd0, 32'd0, 3'd0);
      check32("intr eie core1", {30'd0, intr}, 32'd2);
      step(1'b0, 1'b0, 1'b1, 6'd11, 32'd0, 32'd0, 32'd0, 3'd0);
      check32("eie width", rdata, 32'd2);
      idle();
      check32("rdata idle", rdata, 32'd0);

      // Randomized traffic against the model.
      step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 3'd0);
      model_step(1'b1, 1'b0, 1'b0, 0, 32'd0, 32'd0, 32'd0, 0);
      for (int k = 0; k < 3000; k++) begin
         logic          rst, w, r;
         logic [AW-1:0] a;
         logic [31:0]   d, fr, er;
         logic [IW-1:0] m;
         rst = ($urandom_range(0, 149) == 0);
         w   = 1'($urandom_range(0, 1));
         r   = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 11));
         d   = ($urandom_range(0, 1) == 1) ? $urandom : (32'd1 << $urandom_range(0, 31));
         fr  = ($urandom_range(0, 2) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
         er  = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : 32'd0;
         m   = 3'($urandom);
         model_step(rst, w, r, int'(a), d, fr, er, int'(m));
         step(rst, w, r, a, d, fr, er, m);
         check32($sformatf("rand%0d rdata", k), rdata, m_rd);
         check32($sformatf("rand%0d intr", k), {30'd0, intr}, {30'd0, model_intr()});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/hsem_irq_ctrl.md
Name: hsem_irq_ctrl

Overview:
- Parametrised interrupt/error controller for the HSEM block; supersedes the fixed two-core, single-interrupt-register scheme.
- Per core: free-event pending, enable mask, software interrupt, and a level interrupt output.
- Globally: sticky per-semaphore error flags, a first-error capture and a saturating error counter.
- Sits between the semaphore core (event pulses) and the AHB register slave (decoded wr_en/rd_en/addr).

Parameters:
- NUM_CORES, 2, number of cores / interrupt outputs (1..8).
- NUM_SEMS, 32, number of semaphores (1..32).
- AW, 6, register word-address width; must satisfy 2^AW >= 4*NUM_CORES+4.
- CNT_W, 8, error counter width.
- CID_W, 3, core-ID width.

Ports:
- hclk  in  1  clock, all logic on rising edge.
- hreset  in  1  reset, synchronous, active-high.
- wr_en  in  1  register write strobe.
- rd_en  in  1  register read strobe.
- addr  in  AW  register word address.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- sem_free  in  NUM_SEMS  1-cycle pulse per semaphore released.
- sem_err  in  NUM_SEMS  1-cycle pulse per semaphore access error.
- err_master  in  CID_W  core causing sem_err this cycle.
- intr  out  NUM_CORES  level interrupt per core.

Behaviour:
- Reset: synchronous active-high on hclk. All registers 0; rdata=0, intr=0 the cycle after hreset is sampled high. Reset overrides any same-cycle event or access.
- Register map (word addresses), per core c at base 4c:
  - +0 IER[c] (RW, NUM_SEMS bits).
  - +1 ISR[c] (W1C).
  - +2 MISR[c] (RO, = ISR[c] & IER[c]).
  - +3 SWI[c] (bit0 RW).
- Global registers at G = 4*NUM_CORES:
  - G+0 ERR (W1C, NUM_SEMS bits).
  - G+1 FERR (RO fields; any write clears).
  - G+2 ECNT (any write clears).
  - G+3 EIE (RW, NUM_CORES bits; EIE[c] routes errors to core c).
- ISR[c] bit i sets when sem_free[i]=1, for every core regardless of IER.
- ERR bit i sets when sem_err[i]=1.
- Same cycle, same bit, set and W1C: set wins (bit stays 1).
- FERR = {valid[31], master[16+:CID_W], sem_idx[0+:5]}. When valid=0 and |sem_err, it captures the lowest set index and err_master, then valid=1. Further errors do not overwrite until cleared. Clear and a new error in the same cycle: the new error is captured.
- ECNT increments by 1 in each cycle with |sem_err (not popcount) and saturates at 2^CNT_W-1. Clear and an error in the same cycle: ECNT=1.
- intr[c] = |MISR[c] | SWI[c] | (EIE[c] & |ERR), combinational from registers. An event at cycle N is visible on intr at N+1.
- Reads: rdata is valid the cycle after rd_en and reflects pre-write state if a write to the same address occurs in the same cycle. rdata=0 when no rd_en the previous cycle, for unmapped addresses, and for bits above register width.
- Writes to RO or unmapped addresses are ignored. Write bits above register width are ignored.

Test Plan:
- Reset: hreset high 1 cycle mid-activity with ISR/ERR nonzero -> next cycle all registers 0, intr=0, rdata=0.
- Free interrupt: IER[1]=0x0000_0004, pulse sem_free[2] at N -> intr[1]=1 at N+1, intr[0]=0. Read MISR[1] -> 0x4. W1C 0x4 -> intr[1]=0 next cycle.
- Set/clear collision: W1C ISR[0] bit 5 in the same cycle as sem_free[5] -> ISR[0] bit 5 stays 1. Separate write of 0x20 clears it.
- First error: EIE=0b01, sem_err=0x0000_0300 with err_master=1 at N -> intr[0]=1 at N+1, ERR=0x300, FERR=0x8001_0008. Second error sem_err[0] with master=0 -> FERR unchanged.
- Counter saturation: CNT_W=8, 300 consecutive error cycles -> ECNT=255. Write ECNT with an error in the same cycle -> ECNT=1.
- SWI and read timing: write SWI[0]=1 and read SWI[0] in the same cycle -> rdata=0 next cycle, intr[0]=1. Unmapped read -> rdata=0.
